// File: rtl/rx_frame_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// rx_frame_fifo: store-and-forward RX frame buffer that drops errored/oversize frames
// Revision: 1.0
//------------------------------------------------------------------------------
module rx_frame_fifo #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [15:0]       drop_count,
  output logic              drop_pulse
);

  localparam int              ENTRY_W = DATA_W + KEEP_W + 1;
  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W:0]     wr_ptr;
  logic [ADDR_W:0]     wr_ptr_nxt;
  logic [ADDR_W:0]     wr_ptr_inc;
  logic [ADDR_W:0]     wr_commit;
  logic [ADDR_W:0]     wr_commit_nxt;
  logic [ADDR_W:0]     rd_ptr;
  logic [ADDR_W:0]     occupancy;
  logic                full;
  logic                wr_en;
  logic                drop;
  logic                avail;
  logic                load;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  rd_entry;

  // Occupancy never exceeds DEPTH, so its MSB alone flags the full condition.
  assign occupancy  = wr_ptr - rd_ptr;
  assign full       = occupancy[ADDR_W];
  assign wr_ptr_inc = wr_ptr + PTR_ONE;

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    wr_commit_nxt = wr_commit;
    wr_en         = 1'b0;
    drop          = 1'b0;
    if (s_axis_tvalid) begin
      case (state)
        ACCEPT: begin
          if (!full) begin
            if (!s_axis_tlast) begin
              wr_en      = 1'b1;
              wr_ptr_nxt = wr_ptr_inc;
            end else if (!s_axis_tuser) begin
              wr_en         = 1'b1;
              wr_ptr_nxt    = wr_ptr_inc;
              wr_commit_nxt = wr_ptr_inc;
            end else begin
              wr_ptr_nxt = wr_commit;
              drop       = 1'b1;
            end
          end else begin
            // Overflow rewinds the partial frame; the tail is swallowed in DROP.
            wr_ptr_nxt = wr_commit;
            drop       = 1'b1;
            if (!s_axis_tlast) begin
              state_nxt = DROP;
            end
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            state_nxt = ACCEPT;
          end
        end
        default: state_nxt = ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCEPT;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      wr_commit <= wr_commit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
  end

  // Only committed words are visible to the read side.
  assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];
  assign avail    = (rd_ptr != wr_commit);
  assign load     = (!m_axis_tvalid || m_axis_tready) && avail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      rd_ptr        <= rd_ptr + PTR_ONE;
      m_axis_tdata  <= rd_entry[DATA_W-1:0];
      m_axis_tkeep  <= rd_entry[DATA_W +: KEEP_W];
      m_axis_tlast  <= rd_entry[ENTRY_W-1];
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_rx_frame_fifo: directed self-checking bench for rx_frame_fifo (ADDR_W=4)
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_rx_frame_fifo;

  localparam int ADDR_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [15:0] drop_count;
  logic        drop_pulse;

  always #5 clk = ~clk;

  rx_frame_fifo #(
    .DATA_W(64),
    .KEEP_W(8),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tuser (s_axis_tuser),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .drop_count   (drop_count),
    .drop_pulse   (drop_pulse)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pulses = 0;
  int          p0;
  logic [79:0] got_q[$];
  logic [79:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [79:0] prev_word  = '0;
  logic [79:0] mon_word;

  function automatic logic [79:0] pack(input logic l, input logic [7:0] k, input logic [63:0] d);
    return {7'd0, l, k, d};
  endfunction

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: records handshakes and checks outputs hold during stalls.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon_word = {6'd0, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (prev_stall) begin
        chk("hold", mon_word, prev_word);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(pack(m_axis_tlast, m_axis_tkeep, m_axis_tdata));
      end
      if (drop_pulse) begin
        n_pulses++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = mon_word;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] base, input int n, input logic [7:0] last_keep,
                            input logic user, input bit expect_out);
    logic       lst;
    logic [7:0] k;
    for (int i = 0; i < n; i++) begin
      lst = (i == n - 1);
      k   = lst ? last_keep : 8'hFF;
      if (expect_out) begin
        exp_q.push_back(pack(lst, k, base + 64'(i)));
      end
      send_word(base + 64'(i), k, lst, lst && user);
    end
  endtask

  task automatic compare_out(input string tag);
    chk({tag, "_count"}, 80'(got_q.size()), 80'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    m_axis_tready = 1'b0;
    drain(3);
    chk("rst_tvalid", 80'(m_axis_tvalid), 80'd0);
    chk("rst_tdata", 80'(m_axis_tdata), 80'd0);
    chk("rst_tkeep", 80'(m_axis_tkeep), 80'd0);
    chk("rst_tlast", 80'(m_axis_tlast), 80'd0);
    chk("rst_drop_count", 80'(drop_count), 80'd0);
    chk("rst_drop_pulse", 80'(drop_pulse), 80'd0);
    rst_n = 1'b1;
    tick();

    // Good 3-word frame; first word appears one edge after the tlast edge.
    m_axis_tready = 1'b1;
    exp_q.push_back(pack(1'b0, 8'hFF, 64'h0706050403020100));
    exp_q.push_back(pack(1'b0, 8'hFF, 64'h0F0E0D0C0B0A0908));
    exp_q.push_back(pack(1'b1, 8'h0F, 64'h0000000013121110));
    send_word(64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
    send_word(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 1'b0);
    send_word(64'h0000000013121110, 8'h0F, 1'b1, 1'b0);
    chk("t1_early_valid", 80'(m_axis_tvalid), 80'd0);
    tick();
    chk("t1_first_valid", 80'(m_axis_tvalid), 80'd1);
    chk("t1_first_data", 80'(m_axis_tdata), 80'h0706050403020100);
    chk("t1_first_last", 80'(m_axis_tlast), 80'd0);
    drain(10);
    compare_out("t1");
    chk("t1_drop_count", 80'(drop_count), 80'd0);
    chk("t1_drop_pulse", 80'(drop_pulse), 80'd0);

    // Errored 4-word frame, then a 2-word good frame.
    p0 = n_pulses;
    send_frame(64'h1000, 4, 8'hFF, 1'b1, 1'b0);
    chk("t2_pulse", 80'(drop_pulse), 80'd1);
    chk("t2_count", 80'(drop_count), 80'd1);
    tick();
    chk("t2_pulse_clear", 80'(drop_pulse), 80'd0);
    send_frame(64'h1100, 2, 8'h07, 1'b0, 1'b1);
    drain(10);
    compare_out("t2");
    chk("t2_npulse", 80'(n_pulses - p0), 80'd1);
    chk("t2_count_final", 80'(drop_count), 80'd1);

    // 20-word frame into a 16-word buffer with tready low.
    m_axis_tready = 1'b0;
    p0 = n_pulses;
    send_frame(64'h4000, 20, 8'hFF, 1'b0, 1'b0);
    tick();
    chk("t3_count", 80'(drop_count), 80'd2);
    chk("t3_npulse", 80'(n_pulses - p0), 80'd1);
    chk("t3_no_valid", 80'(m_axis_tvalid), 80'd0);
    send_frame(64'h5000, 4, 8'h3F, 1'b0, 1'b1);
    drain(3);
    chk("t3_none_out", 80'(got_q.size()), 80'd0);
    chk("t3_valid_loaded", 80'(m_axis_tvalid), 80'd1);
    m_axis_tready = 1'b1;
    drain(10);
    compare_out("t3");

    // Back-to-back 5- and 1-word frames under alternating tready.
    fork
      begin
        send_frame(64'h6000, 5, 8'h01, 1'b0, 1'b1);
        send_frame(64'h7000, 1, 8'h03, 1'b0, 1'b1);
      end
      begin
        for (int i = 0; i < 30; i++) begin
          m_axis_tready = ~i[0];
          tick();
        end
        m_axis_tready = 1'b1;
      end
    join
    drain(10);
    compare_out("t4");

    // Full boundary: one word parked in the output register, then 15+1 words
    // fill the 16-entry buffer exactly; one more frame must be dropped.
    m_axis_tready = 1'b0;
    send_frame(64'h8000, 1, 8'h01, 1'b0, 1'b1);
    drain(2);
    send_frame(64'h9000, 15, 8'hFF, 1'b0, 1'b1);
    chk("t5_count_15", 80'(drop_count), 80'd2);
    send_frame(64'hA000, 1, 8'h0F, 1'b0, 1'b1);
    chk("t5_fit_count", 80'(drop_count), 80'd2);
    chk("t5_fit_pulse", 80'(drop_pulse), 80'd0);
    send_frame(64'hB000, 1, 8'h0F, 1'b0, 1'b0);
    chk("t5_drop_count", 80'(drop_count), 80'd3);
    chk("t5_drop_pulse", 80'(drop_pulse), 80'd1);
    m_axis_tready = 1'b1;
    drain(30);
    compare_out("t5");

    // Reset in the middle of readout, then a fresh frame.
    send_frame(64'hC000, 8, 8'hFF, 1'b0, 1'b0);
    drain(2);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", 80'(m_axis_tvalid), 80'd0);
    chk("t6_rst_count", 80'(drop_count), 80'd0);
    chk("t6_rst_pulse", 80'(drop_pulse), 80'd0);
    rst_n = 1'b1;
    got_q.delete();
    exp_q.delete();
    tick();
    send_frame(64'hD000, 3, 8'h1F, 1'b0, 1'b1);
    drain(10);
    compare_out("t6");
    chk("t6_count_final", 80'(drop_count), 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
